inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter REGWIDTH, default 32, datapath/address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  REGWIDTH  word address of request.
REQ-007 SHALL have port imem_ack  input  1  memory response valid; imem_rdata sampled this cycle.
REQ-008 SHALL have port imem_rdata  input  REGWIDTH  fetched instruction word.
REQ-009 SHALL have port inst  output  REGWIDTH  instruction presented to core.
REQ-010 SHALL have port PC  output  REGWIDTH  address of presented inst.
REQ-011 SHALL have port inst_valid  output  1  inst/PC valid.
REQ-012 SHALL have port inst_ready  input  1  core consumes inst this cycle.
REQ-013 SHALL have port redirect  input  1  core requests control-flow change (taken branch/jump).
REQ-014 SHALL have port redirect_pc  input  REGWIDTH  redirect target (core PCout).
REQ-015 SHALL have port misalign_err  output  1  sticky flag, redirect target had [1:0] != 0.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, HOLD, DRAIN.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the internal fetch PC, stable until imem_ack.
REQ-019 FETCH + imem_ack (ack may arrive in the same cycle req first rises) SHALL latch imem_rdata into inst, fetch PC into PC, go HOLD; inst_valid = 1 from the next cycle.
REQ-020 Minimum latency: FETCH entry to inst_valid = 1 cycle with zero-wait memory; each wait cycle adds one.
REQ-021 In HOLD, imem_req SHALL be 0; inst and PC SHALL hold stable while inst_valid=1 and inst_ready=0.
REQ-022 HOLD + inst_ready=1 + redirect=0: fetch PC <= PC + 4 (mod 2^REGWIDTH, 32'hFFFF_FFFC wraps to 0), inst_valid <= 0, go FETCH.
REQ-023 Redirect in HOLD (any inst_ready): fetch PC <= {redirect_pc[REGWIDTH-1:2],2'b00}, inst_valid <= 0, go FETCH; redirect wins over inst_ready.
REQ-024 Redirect in FETCH without imem_ack: store target, go DRAIN; imem_req stays 1 with original imem_addr until ack.
REQ-025 Redirect in FETCH with imem_ack same cycle: discard imem_rdata, fetch PC <= target, stay FETCH (new request next cycle).
REQ-026 DRAIN: imem_req=1 at old address; on imem_ack discard data, go FETCH at stored target; inst_valid stays 0.
REQ-027 A further redirect during DRAIN SHALL overwrite the stored target (last wins).
REQ-028 imem_ack outside FETCH/DRAIN SHALL be ignored.
REQ-029 Redirect in IDLE SHALL set fetch PC to target; first fetch uses it.
REQ-030 Any accepted redirect with redirect_pc[1:0] != 0 SHALL set misalign_err; cleared only by reset.
REQ-031 inst_valid SHALL never be 1 for a word fetched before the most recent redirect.

Reset
REQ-032 rst=1 at a clock edge SHALL force: state IDLE, fetch PC = RESET_PC, PC = RESET_PC, inst = 0, inst_valid = 0, imem_req = 0, imem_addr = RESET_PC, misalign_err = 0, stored target = 0.
REQ-033 Reset mid-transaction (FETCH/DRAIN/HOLD) SHALL abandon it; any imem_ack in the reset cycle or following IDLE cycle is ignored.

Verification
REQ-034 Zero-wait memory returning addr^32'hA5A5_0000, inst_ready=1 always -> PC sequence 0,4,8,12, each inst matches, one inst per 2 cycles.
REQ-035 imem_ack delayed 3 cycles at addr 0x10 -> imem_addr stable 0x10 for 4 cycles, inst_valid rises cycle after ack.
REQ-036 HOLD with inst_ready=0 for 5 cycles, then redirect=1 to 0x200 -> inst/PC stable 5 cycles, next imem_addr=0x200, old inst never consumed.
REQ-037 Redirect to 0x80 during outstanding fetch of 0x8 (ack 2 cycles later) -> DRAIN, 0x8 data dropped, next request 0x80, first valid PC=0x80.
REQ-038 Redirect to 0x102 -> imem_addr 0x100, misalign_err=1 until rst.
REQ-039 Fetch PC 32'hFFFF_FFFC consumed -> next imem_addr 0x0; rst asserted mid-FETCH -> all outputs at REQ-032 values next cycle.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: one outstanding memory read, hold-until-consumed, redirect with drain
module inst_fetch #(
  parameter int                  REGWIDTH = 32,
  parameter logic [REGWIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [REGWIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [REGWIDTH-1:0] imem_rdata,
  output logic [REGWIDTH-1:0] inst,
  output logic [REGWIDTH-1:0] PC,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                redirect,
  input  logic [REGWIDTH-1:0] redirect_pc,
  output logic                misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [REGWIDTH-1:0] fetch_pc, fetch_pc_n;
  logic [REGWIDTH-1:0] target, target_n;
  logic [REGWIDTH-1:0] pc_n, inst_n;
  logic                misalign_n;
  logic [REGWIDTH-1:0] redir_tgt;

  assign redir_tgt  = {redirect_pc[REGWIDTH-1:2], 2'b00};
  assign imem_addr  = fetch_pc;
  assign inst_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      target       <= '0;
      PC           <= RESET_PC;
      inst         <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      fetch_pc     <= fetch_pc_n;
      target       <= target_n;
      PC           <= pc_n;
      inst         <= inst_n;
      misalign_err <= misalign_n;
    end
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    target_n   = target;
    pc_n       = PC;
    inst_n     = inst;
    imem_req   = 1'b0;
    // every state accepts a redirect, so the sticky flag needs no state qualifier
    misalign_n = misalign_err | (redirect & (|redirect_pc[1:0]));
    case (state)
      IDLE: begin
        state_n = FETCH;
        if (redirect) fetch_pc_n = redir_tgt;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_ack) begin
            fetch_pc_n = redir_tgt;
          end else begin
            target_n = redir_tgt;
            state_n  = DRAIN;
          end
        end else if (imem_ack) begin
          inst_n  = imem_rdata;
          pc_n    = fetch_pc;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          fetch_pc_n = redir_tgt;
          state_n    = FETCH;
        end else if (inst_ready) begin
          fetch_pc_n = fetch_pc + REGWIDTH'(4);
          state_n    = FETCH;
        end
      end
      DRAIN: begin
        // the stale request must complete at its original address before retargeting
        imem_req = 1'b1;
        if (redirect) target_n = redir_tgt;
        if (imem_ack) begin
          fetch_pc_n = redirect ? redir_tgt : target;
          state_n    = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed and randomized checks of inst_fetch against a program-order model
module tb_inst_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] PC;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch #(.REGWIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .PC(PC), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},     32'd0);
    chk({tag, "_addr"},  imem_addr,             32'd0);
    chk({tag, "_pc"},    PC,                    32'd0);
    chk({tag, "_inst"},  inst,                  32'd0);
    chk({tag, "_valid"}, {31'd0, inst_valid},   32'd0);
    chk({tag, "_mis"},   {31'd0, misalign_err}, 32'd0);
  endtask

  // random-phase model state: next program-order PC, sticky misalign, memory responder
  logic [31:0] exp_pc, prev_inst, prev_pc, prev_addr;
  logic        exp_mis, busy, prev_valid, prev_hold, prev_pend;
  int          wait_left, no_valid;

  initial begin
    cyc();
    cyc();
    chk_reset("reset");
    rst = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("fetch_after_idle", {31'd0, imem_req}, 32'd1);

    // zero-wait stream with the core always ready
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_req", {31'd0, imem_req}, 32'd1);
      chk("seq_addr", imem_addr, 32'(i * 4));
      imem_ack = 1'b1;
      imem_rdata = 32'(i * 4) ^ KEY;
      cyc();
      imem_ack = 1'b0;
      chk("seq_valid", {31'd0, inst_valid}, 32'd1);
      chk("seq_pc", PC, 32'(i * 4));
      chk("seq_inst", inst, 32'(i * 4) ^ KEY);
      chk("seq_req_hold", {31'd0, imem_req}, 32'd0);
      cyc();
    end

    // three wait cycles at 0x10
    for (int k = 0; k < 4; k++) begin
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_valid", {31'd0, inst_valid}, 32'd0);
      imem_ack = (k == 3);
      imem_rdata = 32'h10 ^ KEY;
      cyc();
    end
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_pc", PC, 32'h10);
      chk("stall_inst", inst, 32'h10 ^ KEY);
      cyc();
    end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    inst_ready = 1'b1;
    cyc();
    redirect = 1'b0;
    inst_ready = 1'b0;
    chk("redir_valid", {31'd0, inst_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h200);
    imem_ack = 1'b1;
    imem_rdata = 32'h200 ^ KEY;
    cyc();
    imem_ack = 1'b0;
    chk("redir_pc", PC, 32'h200);

    // redirect while fetch of 0x8 is outstanding
    redirect = 1'b1;
    redirect_pc = 32'h8;
    cyc();
    chk("drain_first_addr", imem_addr, 32'h8);
    redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0;
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h8);
    cyc();
    chk("drain_addr2", imem_addr, 32'h8);
    imem_ack = 1'b1;
    imem_rdata = 32'h8 ^ KEY;
    cyc();
    chk("drain_drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("drain_new_addr", imem_addr, 32'h80);
    imem_rdata = 32'h80 ^ KEY;
    cyc();
    imem_ack = 1'b0;
    chk("drain_first_pc", PC, 32'h80);
    chk("drain_first_inst", inst, 32'h80 ^ KEY);

    // misaligned redirect
    redirect = 1'b1;
    redirect_pc = 32'h102;
    cyc();
    redirect = 1'b0;
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_flag", {31'd0, misalign_err}, 32'd1);
    imem_ack = 1'b1;
    imem_rdata = 32'h100 ^ KEY;
    cyc();
    imem_ack = 1'b0;
    chk("mis_pc", PC, 32'h100);

    // wrap from the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFC ^ KEY;
    cyc();
    imem_ack = 1'b0;
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_mis_sticky", {31'd0, misalign_err}, 32'd1);

    // reset mid-fetch with acks in the reset and idle cycles
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    chk_reset("midrst");
    rst = 1'b0;
    cyc();
    imem_ack = 1'b0;
    chk("post_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("post_rst_inst", inst, 32'd0);
    chk("post_rst_addr", imem_addr, 32'd0);

    // redirect during idle retargets the first fetch
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    redirect = 1'b0;
    chk("idle_redir_addr", imem_addr, 32'h40);

    // randomized phase
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_pc = 32'd0; exp_mis = 1'b0; busy = 1'b0; wait_left = 0; no_valid = 0;
    prev_valid = 1'b0; prev_hold = 1'b0; prev_pend = 1'b0;
    prev_inst = '0; prev_pc = '0; prev_addr = '0;
    for (int n = 0; n < 3000; n++) begin
      if (inst_valid) begin
        no_valid = 0;
        chk("rnd_pc", PC, exp_pc);
        chk("rnd_inst", inst, exp_pc ^ KEY);
      end else begin
        no_valid++;
        if (no_valid == 80) chk("rnd_progress_timeout", 32'(no_valid), 32'd0);
      end
      if (prev_valid && prev_hold) begin
        chk("rnd_hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("rnd_hold_inst", inst, prev_inst);
        chk("rnd_hold_pc", PC, prev_pc);
      end
      if (prev_pend) begin
        chk("rnd_req_stable", {31'd0, imem_req}, 32'd1);
        chk("rnd_addr_stable", imem_addr, prev_addr);
      end
      chk("rnd_mis", {31'd0, misalign_err}, {31'd0, exp_mis});

      inst_ready = $urandom_range(0, 1) == 1;
      redirect = $urandom_range(0, 9) == 0;
      redirect_pc = $urandom & 32'h0000_0FFF;
      if (imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wait_left = $urandom_range(0, 3);
        end
        imem_ack = (wait_left == 0);
        imem_rdata = imem_addr ^ KEY;
        if (imem_ack) busy = 1'b0;
        else wait_left--;
      end else begin
        imem_ack = $urandom_range(0, 7) == 0;
        imem_rdata = $urandom;
      end

      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        exp_mis = exp_mis | (redirect_pc[1:0] != 2'b00);
      end else if (inst_valid && inst_ready) begin
        exp_pc = exp_pc + 32'd4;
      end
      prev_valid = inst_valid;
      prev_hold = !inst_ready && !redirect;
      prev_inst = inst;
      prev_pc = PC;
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
